// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply protocol controller: state codes,
// the default frame header and width helpers.
package mm_pkg;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_RX_SIZE   = 4'd1;
  localparam logic [3:0] ST_RX_A      = 4'd2;
  localparam logic [3:0] ST_RX_B      = 4'd3;
  localparam logic [3:0] ST_START     = 4'd4;
  localparam logic [3:0] ST_WAIT_DONE = 4'd5;
  localparam logic [3:0] ST_TX_FETCH  = 4'd6;
  localparam logic [3:0] ST_TX_SEND   = 4'd7;
  localparam logic [3:0] ST_TX_WAIT   = 4'd8;
  localparam logic [3:0] ST_ERROR     = 4'd9;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  // Element index width; clamped to 1 so MAX_N=1 still yields a real bus.
  function automatic int calc_aw(input int max_n);
    int w;
    w = $clog2(max_n * max_n);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int calc_sw(input int max_n);
    return $clog2(max_n + 1);
  endfunction

  function automatic int calc_bw(input int res_bytes);
    int w;
    w = $clog2(res_bytes);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/mm_result_serializer.sv
// Splits one result element into bytes (MSB first) and runs the per-byte
// handshake with the UART transmitter.
module mm_result_serializer
  import mm_pkg::*;
#(
  parameter int RES_BYTES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_i,
  input  logic [8*RES_BYTES-1:0] data_i,
  input  logic                   send_i,
  input  logic                   wait_i,
  input  logic                   tx_busy_i,
  output logic                   tx_start_o,
  output logic [7:0]             tx_data_o,
  output logic                   fire_o,
  output logic                   adv_o,
  output logic                   last_o
);

  localparam int BW = calc_bw(RES_BYTES);
  localparam int DW = 8 * RES_BYTES;

  logic [DW-1:0] shift_q, shift_d;
  logic [BW-1:0] idx_q, idx_d;
  logic          first_q, first_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;

  assign fire_o = send_i & ~tx_busy_i;
  // The transmitter raises busy only after seeing tx_start, so the first
  // wait cycle carries stale busy information and is skipped.
  assign adv_o  = wait_i & ~first_q & ~tx_busy_i;
  assign last_o = (idx_q == BW'(RES_BYTES - 1));

  always_comb begin
    shift_d    = shift_q;
    idx_d      = idx_q;
    first_d    = first_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    if (load_i) begin
      shift_d = data_i;
      idx_d   = '0;
    end
    if (fire_o) begin
      tx_start_d = 1'b1;
      tx_data_d  = shift_q[DW-1 -: 8];
      first_d    = 1'b1;
    end
    if (wait_i && first_q) begin
      first_d = 1'b0;
    end
    if (adv_o && !last_o) begin
      shift_d = shift_q << 8;
      idx_d   = idx_q + BW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q    <= '0;
      idx_q      <= '0;
      first_q    <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      shift_q    <= shift_d;
      idx_q      <= idx_d;
      first_q    <= first_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign tx_start_o = tx_start_q;
  assign tx_data_o  = tx_data_q;

endmodule

// File: rtl/mm_ctrl_param.sv
// Frame receiver and sequencer for the UART matrix-multiply datapath.
// state      | meaning
// IDLE       | waiting for header byte
// RX_SIZE    | waiting for matrix size N
// RX_A/RX_B  | receiving N*N operand bytes into buffer A / B
// START      | pulsing mult_start
// WAIT_DONE  | waiting for multiplier completion
// TX_FETCH   | reading one result element (addr cycle, then capture)
// TX_SEND    | issuing tx_start once the transmitter is free
// TX_WAIT    | waiting for the transmitter to finish the byte
// ERROR      | one-cycle error state, back to IDLE
module mm_ctrl_param
  import mm_pkg::*;
#(
  parameter int         MAX_N     = 8,
  parameter int         RES_BYTES = 2,
  parameter logic [7:0] HEADER    = HEADER_DEFAULT,
  parameter int         TIMEOUT   = 1_000_000,
  localparam int        AW        = calc_aw(MAX_N),
  localparam int        SW        = calc_sw(MAX_N)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_valid,
  input  logic [7:0]             rx_data,
  input  logic                   tx_busy,
  input  logic                   mult_done,
  input  logic [8*RES_BYTES-1:0] res_rd_data,
  output logic                   wr_en_a,
  output logic                   wr_en_b,
  output logic [AW-1:0]          wr_addr,
  output logic [7:0]             wr_data,
  output logic [SW-1:0]          matrix_size,
  output logic                   mult_start,
  output logic [AW-1:0]          res_rd_addr,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   busy,
  output logic                   error,
  output logic [3:0]             state
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LOAD = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAX_N_B  = 8'(MAX_N);

  logic [3:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] size_q, size_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          err_q, err_d;
  logic          wr_en_a_q, wr_en_a_d, wr_en_b_q, wr_en_b_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          mult_start_q, mult_start_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          fetch_ph_q, fetch_ph_d;

  logic [CW-1:0] size_ext, nn, last_idx, cnt_nx;
  logic          in_rx, timeout, at_last, size_bad;
  logic          ser_load, ser_fire, ser_adv, ser_last;

  // Count is one bit wider than the element index so N*N never wraps.
  assign size_ext = CW'(size_q);
  assign nn       = size_ext * size_ext;
  assign last_idx = nn - CW'(1);
  assign cnt_nx   = cnt_q + CW'(1);
  assign at_last  = (cnt_q == last_idx);
  assign size_bad = (rx_data == 8'd0) || (rx_data > MAX_N_B);
  assign in_rx    = (state_q == ST_RX_SIZE) || (state_q == ST_RX_A) ||
                    (state_q == ST_RX_B);
  assign timeout  = in_rx && !rx_valid && (timer_q == '0);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    size_d       = size_q;
    err_d        = err_q;
    wr_en_a_d    = 1'b0;
    wr_en_b_d    = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    mult_start_d = 1'b0;
    rd_addr_d    = rd_addr_q;
    fetch_ph_d   = 1'b0;
    ser_load     = 1'b0;
    timer_d      = timer_q;

    // An arriving byte always reloads, so it wins over a same-cycle expiry.
    if (rx_valid) begin
      timer_d = TMR_LOAD;
    end else if (in_rx && timer_q != '0) begin
      timer_d = timer_q - TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (rx_valid && rx_data == HEADER) begin
          state_d = ST_RX_SIZE;
          err_d   = 1'b0;
        end
      end
      ST_RX_SIZE: begin
        if (rx_valid) begin
          if (size_bad) begin
            state_d = ST_ERROR;
            err_d   = 1'b1;
          end else begin
            size_d  = rx_data[SW-1:0];
            cnt_d   = '0;
            state_d = ST_RX_A;
          end
        end else if (timeout) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end
      end
      ST_RX_A, ST_RX_B: begin
        if (rx_valid) begin
          wr_en_a_d = (state_q == ST_RX_A);
          wr_en_b_d = (state_q == ST_RX_B);
          wr_addr_d = cnt_q[AW-1:0];
          wr_data_d = rx_data;
          if (at_last) begin
            cnt_d   = '0;
            state_d = (state_q == ST_RX_A) ? ST_RX_B : ST_START;
          end else begin
            cnt_d = cnt_nx;
          end
        end else if (timeout) begin
          state_d = ST_ERROR;
          err_d   = 1'b1;
        end
      end
      ST_START: begin
        mult_start_d = 1'b1;
        state_d      = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (mult_done) begin
          cnt_d     = '0;
          rd_addr_d = '0;
          state_d   = ST_TX_FETCH;
        end
      end
      ST_TX_FETCH: begin
        if (!fetch_ph_q) begin
          fetch_ph_d = 1'b1;
        end else begin
          ser_load = 1'b1;
          state_d  = ST_TX_SEND;
        end
      end
      ST_TX_SEND: begin
        if (ser_fire) state_d = ST_TX_WAIT;
      end
      ST_TX_WAIT: begin
        if (ser_adv) begin
          if (!ser_last) begin
            state_d = ST_TX_SEND;
          end else if (at_last) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d     = cnt_nx;
            rd_addr_d = cnt_nx[AW-1:0];
            state_d   = ST_TX_FETCH;
          end
        end
      end
      ST_ERROR: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      size_q       <= '0;
      timer_q      <= '0;
      err_q        <= 1'b0;
      wr_en_a_q    <= 1'b0;
      wr_en_b_q    <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      mult_start_q <= 1'b0;
      rd_addr_q    <= '0;
      fetch_ph_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
      wr_en_a_q    <= wr_en_a_d;
      wr_en_b_q    <= wr_en_b_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      mult_start_q <= mult_start_d;
      rd_addr_q    <= rd_addr_d;
      fetch_ph_q   <= fetch_ph_d;
    end
  end

  mm_result_serializer #(
    .RES_BYTES(RES_BYTES)
  ) u_ser (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (ser_load),
    .data_i    (res_rd_data),
    .send_i    (state_q == ST_TX_SEND),
    .wait_i    (state_q == ST_TX_WAIT),
    .tx_busy_i (tx_busy),
    .tx_start_o(tx_start),
    .tx_data_o (tx_data),
    .fire_o    (ser_fire),
    .adv_o     (ser_adv),
    .last_o    (ser_last)
  );

  assign wr_en_a     = wr_en_a_q;
  assign wr_en_b     = wr_en_b_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign matrix_size = size_q;
  assign mult_start  = mult_start_q;
  assign res_rd_addr = rd_addr_q;
  assign busy        = (state_q != ST_IDLE);
  assign error       = err_q;
  assign state       = state_q;

endmodule

// File: tb/tb_mm_ctrl_param.sv
// Directed bench for mm_ctrl_param (MAX_N=8, 3-byte results, short timeout).
module tb_mm_ctrl_param;
  import mm_pkg::*;

  localparam int MAX_N = 8;
  localparam int RB    = 3;
  localparam int TO    = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        tx_busy = 1'b0;
  logic        mult_done = 1'b0;
  logic [23:0] res_rd_data = 24'd0;

  logic        wr_en_a, wr_en_b, mult_start, tx_start, busy, error;
  logic [5:0]  wr_addr, res_rd_addr;
  logic [7:0]  wr_data, tx_data;
  logic [3:0]  matrix_size, state;

  mm_ctrl_param #(.MAX_N(MAX_N), .RES_BYTES(RB), .HEADER(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_busy(tx_busy), .mult_done(mult_done), .res_rd_data(res_rd_data),
    .wr_en_a(wr_en_a), .wr_en_b(wr_en_b), .wr_addr(wr_addr), .wr_data(wr_data),
    .matrix_size(matrix_size), .mult_start(mult_start), .res_rd_addr(res_rd_addr),
    .tx_start(tx_start), .tx_data(tx_data), .busy(busy), .error(error), .state(state)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0, last_rx_cyc = 0, ms_cyc = 0;
  int busy_len = 0, busy_left = 0, md_cnt = 0;
  int n_wa = 0, n_wb = 0, n_tx = 0, n_ms = 0, n_viol = 0, n_consec = 0;
  logic prev_ts = 1'b0;
  logic [7:0] wa_addr [64];
  logic [7:0] wa_data [64];
  logic [7:0] wb_addr [64];
  logic [7:0] wb_data [64];
  logic [7:0] tx_log  [256];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rx_valid) last_rx_cyc = cyc;
  end

  // Environment: result memory, multiplier and UART models plus logging.
  always @(negedge clk) begin
    if (!rst_n) begin
      n_wa = 0; n_wb = 0; n_tx = 0; n_ms = 0; n_viol = 0; n_consec = 0;
      tx_busy = 1'b0; busy_left = 0; md_cnt = 0; mult_done = 1'b0; prev_ts = 1'b0;
    end else begin
      res_rd_data = {8'h10 + 8'(res_rd_addr), 8'h20 + 8'(res_rd_addr), 8'h30 + 8'(res_rd_addr)};
      if (wr_en_a) begin
        if (n_wa < 64) begin wa_addr[n_wa] = 8'(wr_addr); wa_data[n_wa] = wr_data; end
        n_wa++;
      end
      if (wr_en_b) begin
        if (n_wb < 64) begin wb_addr[n_wb] = 8'(wr_addr); wb_data[n_wb] = wr_data; end
        n_wb++;
      end
      if (mult_done) mult_done = 1'b0;
      if (md_cnt > 0) begin
        md_cnt--;
        if (md_cnt == 0) mult_done = 1'b1;
      end
      if (mult_start) begin n_ms++; ms_cyc = cyc; md_cnt = 3; end
      if (tx_start) begin
        if (tx_busy) n_viol++;
        if (prev_ts) n_consec++;
        if (n_tx < 256) tx_log[n_tx] = tx_data;
        n_tx++;
        if (busy_len > 0) begin tx_busy = 1'b1; busy_left = busy_len; end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      prev_ts = tx_start;
    end
  end

  function automatic logic [7:0] exp_byte(input int j);
    int e, k;
    e = j / 3;
    k = j % 3;
    return 8'((k + 1) * 16 + e);
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'd0; busy_len = 0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (state == ST_IDLE) begin ok = 1'b1; break; end
    end
  endtask

  task automatic send_frame_n2();
    send_byte(8'hA5); send_byte(8'h02);
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
  endtask

  task automatic check_tx_n2(input string tag);
    checks++;
    if (n_tx !== 12) begin errors++; $display("FAIL %s tx_count got %0d want 12", tag, n_tx); end
    for (int j = 0; j < 12 && j < n_tx; j++) begin
      checks++;
      if (tx_log[j] !== exp_byte(j)) begin
        errors++; $display("FAIL %s tx_byte[%0d] got %02h want %02h", tag, j, tx_log[j], exp_byte(j));
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_en_a, wr_en_b, wr_addr, wr_data, matrix_size, mult_start, res_rd_addr,
         tx_start, tx_data, busy, error, state} !== '0) begin
      errors++; $display("FAIL reset_outputs got nonzero state=%0d busy=%b error=%b", state, busy, error);
    end
  endtask

  task automatic test_basic();
    bit ok;
    do_reset();
    busy_len = 2;
    send_frame_n2();
    wait_idle(1000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL basic_done got state=%0d want 0", state); end
    checks++;
    if (n_wa !== 4 || n_wb !== 4) begin
      errors++; $display("FAIL basic_wr_count got a=%0d b=%0d want 4/4", n_wa, n_wb);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({wa_addr[i], wa_data[i], wb_addr[i], wb_data[i]} !== {8'(i), 8'(i + 1), 8'(i), 8'(i + 5)}) begin
        errors++;
        $display("FAIL basic_wr[%0d] got a:%0d/%0d b:%0d/%0d want a:%0d/%0d b:%0d/%0d", i,
                 wa_addr[i], wa_data[i], wb_addr[i], wb_data[i], i, i + 1, i, i + 5);
      end
    end
    checks++;
    if (n_ms !== 1) begin errors++; $display("FAIL basic_mult_start got %0d pulses want 1", n_ms); end
    // Last B byte sampled at edge k; mult_start is seen at the negedge after edge k+1.
    checks++;
    if (ms_cyc !== last_rx_cyc + 1) begin
      errors++; $display("FAIL basic_start_lat got %0d want %0d", ms_cyc, last_rx_cyc + 1);
    end
    check_tx_n2("basic");
    checks++;
    if ({n_viol, n_consec} !== 64'd0) begin
      errors++; $display("FAIL basic_tx_rules got viol=%0d consec=%0d want 0/0", n_viol, n_consec);
    end
    checks++;
    if ({busy, error} !== 2'b00) begin errors++; $display("FAIL basic_end got busy=%b error=%b want 0/0", busy, error); end
  endtask

  task automatic test_bad_size();
    logic [7:0] sz [2];
    sz[0] = 8'h00; sz[1] = 8'h09;
    do_reset();
    for (int t = 0; t < 2; t++) begin
      send_byte(8'hA5);
      send_byte(sz[t]);
      checks++;
      if ({state, error} !== {ST_ERROR, 1'b1}) begin
        errors++; $display("FAIL bad_size_%02h got state=%0d error=%b want 9/1", sz[t], state, error);
      end
      @(negedge clk);
      checks++;
      if ({state, error, busy} !== {ST_IDLE, 1'b1, 1'b0}) begin
        errors++; $display("FAIL bad_size_idle_%02h got state=%0d error=%b busy=%b want 0/1/0", sz[t], state, error, busy);
      end
    end
    checks++;
    if (n_wa + n_wb !== 0) begin errors++; $display("FAIL bad_size_writes got %0d want 0", n_wa + n_wb); end
    send_byte(8'hA5);
    checks++;
    if ({state, error} !== {ST_RX_SIZE, 1'b0}) begin
      errors++; $display("FAIL bad_size_clear got state=%0d error=%b want 1/0", state, error);
    end
  endtask

  task automatic test_ignore();
    do_reset();
    send_byte(8'h3C);
    repeat (2) @(negedge clk);
    checks++;
    if ({state, busy} !== {ST_IDLE, 1'b0}) begin
      errors++; $display("FAIL ignore_3c got state=%0d busy=%b want 0/0", state, busy);
    end
    send_byte(8'hA5);
    checks++;
    if ({state, busy} !== {ST_RX_SIZE, 1'b1}) begin
      errors++; $display("FAIL ignore_hdr got state=%0d busy=%b want 1/1", state, busy);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5); send_byte(8'h03);
    for (int i = 1; i <= 4; i++) send_byte(8'(i));
    repeat (TO - 1) @(negedge clk);
    checks++;
    if ({state, matrix_size} !== {ST_RX_A, 4'd3}) begin
      errors++; $display("FAIL timeout_early got state=%0d size=%0d want 2/3", state, matrix_size);
    end
    @(negedge clk);
    checks++;
    if ({state, error} !== {ST_ERROR, 1'b1}) begin
      errors++; $display("FAIL timeout_expiry got state=%0d error=%b want 9/1", state, error);
    end
    @(negedge clk);
    checks++;
    if ({state, n_wa, n_wb} !== {ST_IDLE, 32'd4, 32'd0}) begin
      errors++; $display("FAIL timeout_after got state=%0d wa=%0d wb=%0d want 0/4/0", state, n_wa, n_wb);
    end
  endtask

  task automatic test_full_size();
    bit ok;
    do_reset();
    busy_len = 10;
    send_byte(8'hA5); send_byte(8'h08);
    for (int i = 0; i < 64; i++) send_byte(8'(i));
    for (int i = 0; i < 64; i++) send_byte(8'(8'h80 + i));
    wait_idle(8000, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL full_done got state=%0d want 0", state); end
    checks++;
    if ({n_wa, n_wb, n_ms} !== {32'd64, 32'd64, 32'd1}) begin
      errors++; $display("FAIL full_counts got wa=%0d wb=%0d ms=%0d want 64/64/1", n_wa, n_wb, n_ms);
    end
    for (int i = 0; i < 64; i++) begin
      checks++;
      if ({wa_addr[i], wa_data[i], wb_addr[i], wb_data[i]} !== {8'(i), 8'(i), 8'(i), 8'(8'h80 + i)}) begin
        errors++; $display("FAIL full_wr[%0d] got a:%0d/%02h b:%0d/%02h", i, wa_addr[i], wa_data[i], wb_addr[i], wb_data[i]);
      end
    end
    checks++;
    if (n_tx !== 192) begin errors++; $display("FAIL full_tx_count got %0d want 192", n_tx); end
    for (int j = 0; j < 192 && j < n_tx; j++) begin
      checks++;
      if (tx_log[j] !== exp_byte(j)) begin
        errors++; $display("FAIL full_tx_byte[%0d] got %02h want %02h", j, tx_log[j], exp_byte(j));
      end
    end
    checks++;
    if ({n_viol, n_consec} !== 64'd0) begin
      errors++; $display("FAIL full_tx_rules got viol=%0d consec=%0d want 0/0", n_viol, n_consec);
    end
  endtask

  task automatic test_reset_tx_wait();
    bit ok;
    bit hit;
    do_reset();
    busy_len = 10;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h07); send_byte(8'h09);
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (state == ST_TX_WAIT) begin hit = 1'b1; break; end
    end
    checks++;
    if (hit !== 1'b1) begin errors++; $display("FAIL rst_reach_tx_wait got state=%0d want 8", state); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_en_a, wr_en_b, wr_addr, wr_data, matrix_size, mult_start, res_rd_addr,
         tx_start, tx_data, busy, error, state} !== '0) begin
      errors++; $display("FAIL rst_async got state=%0d size=%0d tx_data=%02h busy=%b want all 0",
                         state, matrix_size, tx_data, busy);
    end
    busy_len = 0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    send_frame_n2();
    wait_idle(1000, ok);
    checks++;
    if ({ok, n_wa, n_wb} !== {1'b1, 32'd4, 32'd4}) begin
      errors++; $display("FAIL rst_fresh got ok=%b wa=%0d wb=%0d want 1/4/4", ok, n_wa, n_wb);
    end
    check_tx_n2("rst_fresh");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_basic();
    test_bad_size();
    test_ignore();
    test_timeout();
    test_full_size();
    test_reset_tx_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
